dqsw_training_ctrl: RTL and testbench

- Sequences write-leveling (DQSW) delay-line training for one DDR3 lane's DQSW training IOD.
- Sweeps the IOD's dynamic delay line tap by tap and samples the eye-monitor LATE flag at each tap.
- Locates the first early-to-late transition, backs off a fixed number of taps and reports the final tap.
- Sits between the lane training sequencer (START/DONE/FAIL) and the IOD delay-line and eye-monitor pins.

---
 rtl/dqsw_training_pkg.sv | 34 +++
 rtl/dqsw_settle_timer.sv | 35 +++
 rtl/dqsw_training_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_dqsw_training_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dqsw_training_pkg.sv
// DQSW training shared definitions: FSM states, default parameters, per-tap timing.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dqsw_training_pkg;

    localparam int DEF_TAP_W      = 8;
    localparam int DEF_MAX_TAPS   = 127;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_SAMPLES    = 16;
    localparam int DEF_THRESH     = 12;
    localparam int DEF_BACKOFF    = 2;

    // Cycles spent on one tap of the forward sweep:
    // CLEAR + settle + sampling window + EVAL + STEP + settle.
    function automatic int tap_latency(input int settle_cyc, input int samples);
        return 3 + 2 * settle_cyc + samples;
    endfunction

    localparam int TAP_LATENCY = tap_latency(DEF_SETTLE_CYC, DEF_SAMPLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CLEAR,
        S_SAMPLE,
        S_EVAL,
        S_STEP,
        S_REWIND,
        S_FINISH,
        S_FAIL
    } state_t;

endpackage

// File: rtl/dqsw_settle_timer.sv
// Loadable down-counter used to let the IOD settle after a delay-line or flag action.
// Latency: done rises load_val+1 cycles after the load cycle (done is high while count is 0).
// Backpressure: none; a new load restarts the count at any time.
//
// Ports:
//   fab_clk  : clock, rising edge
//   reset    : synchronous active-high reset, count forced to 0
//   load     : load load_val into the counter this cycle
//   load_val : value loaded (cycles to wait minus one)
//   done     : count has reached 0
module dqsw_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             fab_clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge fab_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/dqsw_training_ctrl.sv
// DQSW write-leveling trainer: sweeps one lane's IOD delay line, finds the early->late edge, backs off.
// Latency: 35 cycles per swept tap at default parameters, plus LOAD/settle and rewind steps.
// Backpressure: START is only accepted in IDLE; requests while BUSY are dropped.
//
// Optional build macro: DQSW_TRAIN_CONFIRM_EN -- an edge needs two consecutive late taps after an
// early tap; the first of the pair is reported, so the rewind performs BACKOFF+1 decrements.
//
// Ports:
//   FAB_CLK, RESET                : clock and synchronous active-high reset
//   START / BUSY / DONE / FAIL    : sequencer handshake; DONE and FAIL are sticky until next START
//   TAP_OUT                       : final tap on DONE, tap at failure on FAIL
//   DELAY_LINE_LOAD_0/MOVE_0      : one-cycle pulses to the IOD delay line
//   DELAY_LINE_DIRECTION_0        : 1 = increment, valid the cycle before and during MOVE
//   EYE_MONITOR_CLEAR_FLAGS_0     : one-cycle pulse clearing the eye-monitor flags
//   EYE_MONITOR_EARLY_0/LATE_0    : eye-monitor flags (EARLY currently unused)
//   DELAY_LINE_OUT_OF_RANGE_0     : IOD overflow; aborts training into FAIL
module dqsw_training_ctrl
    import dqsw_training_pkg::*;
#(
    parameter int TAP_W      = DEF_TAP_W,
    parameter int MAX_TAPS   = DEF_MAX_TAPS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int SAMPLES    = DEF_SAMPLES,
    parameter int THRESH     = DEF_THRESH,
    parameter int BACKOFF    = DEF_BACKOFF
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [TAP_W-1:0] TAP_OUT,
    output logic             DELAY_LINE_LOAD_0,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             EYE_MONITOR_CLEAR_FLAGS_0,
    input  logic             EYE_MONITOR_EARLY_0,
    input  logic             EYE_MONITOR_LATE_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

    localparam int LC_W = $clog2(SAMPLES) + 1;     // holds 0..SAMPLES
    localparam int ST_W = $clog2(SETTLE_CYC) + 1;
`ifdef DQSW_TRAIN_CONFIRM_EN
    localparam int RWD_N = BACKOFF + 1;            // edge is detected one tap past the reported one
`else
    localparam int RWD_N = BACKOFF;
`endif
    localparam int RW_W = $clog2(RWD_N + 1) + 1;

    localparam logic [LC_W-1:0]  SAMP_LAST = LC_W'(SAMPLES - 1);
    localparam logic [LC_W-1:0]  THRESH_V  = LC_W'(THRESH);
    localparam logic [TAP_W-1:0] MAX_V     = TAP_W'(MAX_TAPS);
    localparam logic [ST_W-1:0]  SETTLE_V  = ST_W'(SETTLE_CYC - 1);

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;          // where WAIT goes once the settle time expires
    logic [TAP_W-1:0] tap_q;
    logic [LC_W-1:0]  samp_q;
    logic [LC_W-1:0]  late_q;
    logic             seen_early_q;
    logic             rewinding_q;
    logic [RW_W-1:0]  rwd_q;                 // decrements still to issue
    logic             done_q, fail_q;
    logic [TAP_W-1:0] tap_out_q;
    logic             tmr_load, tmr_done;
    logic             late_now, edge_now;
    logic             move_pulse;

    // EARLY is reserved for a future variant of the edge search.
    logic unused_early;
    assign unused_early = EYE_MONITOR_EARLY_0;

    dqsw_settle_timer #(.CNT_W(ST_W)) u_settle (
        .fab_clk  (FAB_CLK),
        .reset    (RESET),
        .load     (tmr_load),
        .load_val (SETTLE_V),
        .done     (tmr_done)
    );

    assign late_now = (late_q >= THRESH_V);

`ifdef DQSW_TRAIN_CONFIRM_EN
    logic confirm_q;                         // one late tap already seen after an early tap
    assign edge_now = late_now && seen_early_q && confirm_q;
`else
    assign edge_now = late_now && seen_early_q;
`endif

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        tmr_load = 1'b0;
        case (state_q)
            S_IDLE:   if (START) state_d = S_LOAD;
            S_LOAD: begin
                state_d  = S_WAIT;
                ret_d    = S_CLEAR;
                tmr_load = 1'b1;
            end
            S_WAIT:   if (tmr_done) state_d = ret_q;
            S_CLEAR: begin
                state_d  = S_WAIT;
                ret_d    = S_SAMPLE;
                tmr_load = 1'b1;
            end
            S_SAMPLE: if (samp_q == SAMP_LAST) state_d = S_EVAL;
            S_EVAL: begin
                if (edge_now)            state_d = (RWD_N == 0) ? S_FINISH : S_REWIND;
                else if (tap_q == MAX_V) state_d = S_FAIL;
                else                     state_d = S_STEP;
            end
            S_STEP: begin
                state_d  = S_WAIT;
                ret_d    = S_CLEAR;
                tmr_load = 1'b1;
            end
            S_REWIND: begin
                // Already at tap 0: nothing left to step back over.
                if (tap_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    state_d  = S_WAIT;
                    ret_d    = (rwd_q <= RW_W'(1)) ? S_FINISH : S_REWIND;
                    tmr_load = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Delay-line overflow overrides everything while training is active.
        if (DELAY_LINE_OUT_OF_RANGE_0 && (state_q != S_IDLE) && (state_q != S_FAIL))
            state_d = S_FAIL;
    end

    assign move_pulse = (state_q == S_STEP) || ((state_q == S_REWIND) && (tap_q != '0));

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            tap_q        <= '0;
            samp_q       <= '0;
            late_q       <= '0;
            seen_early_q <= 1'b0;
            rewinding_q  <= 1'b0;
            rwd_q        <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            tap_out_q    <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        done_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        seen_early_q <= 1'b0;
                        rewinding_q  <= 1'b0;
                        tap_q        <= '0;
                    end
                end
                S_CLEAR: begin
                    samp_q <= '0;
                    late_q <= '0;
                end
                S_SAMPLE: begin
                    samp_q <= samp_q + LC_W'(1);
                    late_q <= late_q + LC_W'(EYE_MONITOR_LATE_0);
                end
                S_EVAL: begin
                    if (!late_now) seen_early_q <= 1'b1;
                    if (edge_now) begin
                        rewinding_q <= 1'b1;
                        rwd_q       <= RW_W'(RWD_N);
                    end
                end
                S_STEP: tap_q <= tap_q + TAP_W'(1);
                S_REWIND: begin
                    if (tap_q != '0) begin
                        tap_q <= tap_q - TAP_W'(1);
                        rwd_q <= rwd_q - RW_W'(1);
                    end
                end
                S_FINISH: begin
                    if (state_d == S_IDLE) begin
                        done_q    <= 1'b1;
                        tap_out_q <= tap_q;
                    end
                end
                S_FAIL: begin
                    fail_q    <= 1'b1;
                    tap_out_q <= tap_q;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DQSW_TRAIN_CONFIRM_EN
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            confirm_q <= 1'b0;
        end else if ((state_q == S_IDLE) && START) begin
            confirm_q <= 1'b0;
        end else if (state_q == S_EVAL) begin
            if (!late_now)         confirm_q <= 1'b0;
            else if (seen_early_q) confirm_q <= 1'b1;
        end
    end
`endif

    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = done_q;
    assign FAIL    = fail_q;
    assign TAP_OUT = tap_out_q;

    assign DELAY_LINE_LOAD_0         = (state_q == S_LOAD);
    assign DELAY_LINE_MOVE_0         = move_pulse;
    assign EYE_MONITOR_CLEAR_FLAGS_0 = (state_q == S_CLEAR);

    // Direction must already be valid the cycle before MOVE. The first MOVE of a phase
    // always follows EVAL, so EVAL drives the upcoming direction from the edge decision.
    assign DELAY_LINE_DIRECTION_0 = (state_q == S_EVAL) ? !edge_now
                                                        : ((state_q != S_IDLE) && !rewinding_q);

endmodule

// File: tb/tb_dqsw_training_ctrl.sv
// Bench for dqsw_training_ctrl: IOD delay-line/eye-monitor model plus table of training scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_dqsw_training_ctrl;
    import dqsw_training_pkg::*;

    logic       FAB_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       BUSY, DONE, FAIL;
    logic [7:0] TAP_OUT;
    logic       LOAD, MOVE, DIR, CLR;
    logic       EARLY = 1'b0;
    logic       LATE = 1'b0;
    logic       OOR = 1'b0;

    always #5 FAB_CLK = ~FAB_CLK;

    dqsw_training_ctrl dut (
        .FAB_CLK                   (FAB_CLK),
        .RESET                     (RESET),
        .START                     (START),
        .BUSY                      (BUSY),
        .DONE                      (DONE),
        .FAIL                      (FAIL),
        .TAP_OUT                   (TAP_OUT),
        .DELAY_LINE_LOAD_0         (LOAD),
        .DELAY_LINE_MOVE_0         (MOVE),
        .DELAY_LINE_DIRECTION_0    (DIR),
        .EYE_MONITOR_CLEAR_FLAGS_0 (CLR),
        .EYE_MONITOR_EARLY_0       (EARLY),
        .EYE_MONITOR_LATE_0        (LATE),
        .DELAY_LINE_OUT_OF_RANGE_0 (OOR)
    );

    typedef struct {
        string name;
        int    lo_a, hi_a;     // first late region (before any early tap), -1 = none
        int    late_from;      // late for every tap at or above this
        int    k;              // LATE samples asserted out of every 16 on a late tap
        int    oor_tap;        // tap where an out-of-range pulse is injected, -1 = none
        int    restart_at;     // wait-loop cycle at which START is re-pulsed, -1 = none
        bit    exp_done, exp_fail;
        int    exp_tap, exp_inc, exp_dec;
    } vec_t;

    localparam int BUDGET = (DEF_MAX_TAPS + 3) * TAP_LATENCY + 100;

    int n_chk = 0;
    int n_fail = 0;
    vec_t sb[$];
    vec_t vecs[7];

    // model state, written only by the model process
    int cfg_lo_a = -1, cfg_hi_a = -1, cfg_late_from = 999, cfg_k = 16, cfg_oor_tap = -1;
    int pos = 0, inc_cnt = 0, dec_cnt = 0, dir_err = 0, n_loads = 0, cyc = 0;
    int oor_wait = 0;
    bit oor_armed = 0;
    bit prev_dir = 0;

    function automatic bit tap_is_late(input int p);
        return ((p >= cfg_lo_a) && (p <= cfg_hi_a)) || (p >= cfg_late_from);
    endfunction

    // IOD model: tracks the delay-line position from LOAD/MOVE and drives LATE/OOR.
    always @(negedge FAB_CLK) begin
        if (LOAD) begin
            pos = 0; inc_cnt = 0; dec_cnt = 0; dir_err = 0;
            n_loads = n_loads + 1;
            oor_armed = (cfg_oor_tap >= 0);
            oor_wait = 0;
        end
        if (MOVE) begin
            if (DIR !== prev_dir) dir_err = dir_err + 1;
            if (DIR) begin pos = pos + 1; inc_cnt = inc_cnt + 1; end
            else     begin pos = pos - 1; dec_cnt = dec_cnt + 1; end
        end
        prev_dir = DIR;
        cyc = cyc + 1;
        OOR = 1'b0;
        if (oor_armed && (pos == cfg_oor_tap)) begin
            oor_wait = oor_wait + 1;
            if (oor_wait == 15) begin OOR = 1'b1; oor_armed = 0; end
        end
        LATE = tap_is_late(pos) && ((cyc % DEF_SAMPLES) < cfg_k);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input int lo_a, input int hi_a, input int late_from,
                                input int k, input int oor_tap, input int restart_at,
                                input bit d, input bit f, input int tap, input int inc, input int dec);
        vec_t v;
        int conf = 0;
`ifdef DQSW_TRAIN_CONFIRM_EN
        conf = 1;
`endif
        v.name = nm; v.lo_a = lo_a; v.hi_a = hi_a; v.late_from = late_from; v.k = k;
        v.oor_tap = oor_tap; v.restart_at = restart_at; v.exp_done = d; v.exp_fail = f;
        v.exp_tap = tap;
        v.exp_inc = inc + (d ? conf : 0);
        v.exp_dec = dec + (d ? conf : 0);
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        vec_t e;
        bit   got;
        int   loads0;
        cfg_lo_a = v.lo_a; cfg_hi_a = v.hi_a; cfg_late_from = v.late_from;
        cfg_k = v.k; cfg_oor_tap = v.oor_tap;
        loads0 = n_loads;
        sb.push_back(v);
        @(negedge FAB_CLK); START = 1'b1;
        @(negedge FAB_CLK); START = 1'b0;
        check({v.name, ":load_pulse"}, LOAD, 1);
        check({v.name, ":busy_start"}, BUSY, 1);
        check({v.name, ":flags_cleared"}, {DONE, FAIL}, 0);
        got = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge FAB_CLK);
            START = (i == v.restart_at);
            if (DONE || FAIL) begin got = 1; break; end
        end
        START = 1'b0;
        e = sb.pop_front();
        check({e.name, ":finished"}, got, 1);
        check({e.name, ":busy_low"}, BUSY, 0);
        check({e.name, ":done"}, DONE, e.exp_done);
        check({e.name, ":fail"}, FAIL, e.exp_fail);
        check({e.name, ":tap_out"}, TAP_OUT, e.exp_tap);
        check({e.name, ":inc_moves"}, inc_cnt, e.exp_inc);
        check({e.name, ":dec_moves"}, dec_cnt, e.exp_dec);
        check({e.name, ":dir_setup_err"}, dir_err, 0);
        check({e.name, ":load_count"}, n_loads - loads0, 1);
        @(negedge FAB_CLK);
        check({e.name, ":sticky"}, {DONE, FAIL}, {e.exp_done, e.exp_fail});
    endtask

    initial begin
        bit reached;
        vecs[0] = mk("edge20",       -1, -1,  20, 16, -1, -1, 1, 0,  18,  20, 2);
        vecs[1] = mk("skip_initial",  0,  3,  10, 16, -1, -1, 1, 0,   8,  10, 2);
        vecs[2] = mk("never_late",   -1, -1, 999, 16, -1, -1, 0, 1, 127, 127, 0);
        vecs[3] = mk("oor_tap5",     -1, -1, 999, 16,  5, -1, 0, 1,   5,   5, 0);
        vecs[4] = mk("late11of16",   -1, -1,   6, 11, -1, -1, 0, 1, 127, 127, 0);
        vecs[5] = mk("late12of16",   -1, -1,   6, 12, -1, -1, 1, 0,   4,   6, 2);
        vecs[6] = mk("start_busy",   -1, -1,  20, 16, -1, 60, 1, 0,  18,  20, 2);

        // power-on reset
        RESET = 1'b1;
        repeat (3) @(negedge FAB_CLK);
        check("por_busy", BUSY, 0);
        check("por_flags", {DONE, FAIL}, 0);
        check("por_tap_out", TAP_OUT, 0);
        check("por_pulses", {LOAD, MOVE, DIR, CLR}, 0);

        // RESET and START together: reset wins
        START = 1'b1;
        @(negedge FAB_CLK);
        RESET = 1'b0; START = 1'b0;
        check("rst_start_busy", BUSY, 0);
        @(negedge FAB_CLK);
        check("rst_start_load", LOAD, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // reset in the middle of sampling at tap 7, then a fresh run
        cfg_lo_a = -1; cfg_hi_a = -1; cfg_late_from = 999; cfg_k = 16; cfg_oor_tap = -1;
        @(negedge FAB_CLK); START = 1'b1;
        @(negedge FAB_CLK); START = 1'b0;
        reached = 0;
        for (int i = 0; i < 12 * TAP_LATENCY; i++) begin
            @(negedge FAB_CLK);
            if (pos == 7) begin reached = 1; break; end
        end
        check("midrst:reached_tap7", reached, 1);
        repeat (20) @(negedge FAB_CLK);
        check("midrst:busy_before", BUSY, 1);
        RESET = 1'b1;
        @(negedge FAB_CLK);
        check("midrst:busy", BUSY, 0);
        check("midrst:flags", {DONE, FAIL}, 0);
        check("midrst:tap_out", TAP_OUT, 0);
        check("midrst:pulses", {LOAD, MOVE, DIR, CLR}, 0);
        RESET = 1'b0;
        repeat (2) @(negedge FAB_CLK);
        check("midrst:idle_after", {BUSY, DONE, FAIL}, 0);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
